// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared definitions for the instruction-cache AXI read bridge:
// request type codes, FSM state encoding, AXI constants and AR payload helper.
package icache_axi_rd_bridge_pkg;

   // One-hot FSM encoding keeps the per-state output decodes to a single bit.
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_AR   = 3'b010,
      ST_R    = 3'b100
   } state_e;

   // Cache-side read type codes.
   localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
   localparam logic [2:0] RD_TYPE_HALF = 3'b001;
   localparam logic [2:0] RD_TYPE_WORD = 3'b010;
   localparam logic [2:0] RD_TYPE_LINE = 3'b100;

   // AXI constants.
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [7:0] ARLEN_LINE     = 8'd7;
   localparam logic [7:0] ARLEN_SINGLE   = 8'd0;

   // AR channel payload captured when a request is accepted.
   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_req_t;

   // Translate a cache request into its AXI read address payload.
   // Reserved type codes fall back to a single word read.
   function automatic ar_req_t build_ar_req(input logic [2:0]  rd_type,
                                            input logic [31:0] rd_addr);
      ar_req_t req;
      req.burst = AXI_BURST_INCR;
      case (rd_type)
         RD_TYPE_LINE: begin
            req.addr = {rd_addr[31:5], 5'b00000};
            req.len  = ARLEN_LINE;
            req.size = AXI_SIZE_WORD;
         end
         RD_TYPE_BYTE, RD_TYPE_HALF, RD_TYPE_WORD: begin
            req.addr = rd_addr;
            req.len  = ARLEN_SINGLE;
            req.size = {1'b0, rd_type[1:0]};
         end
         default: begin
            req.addr = rd_addr;
            req.len  = ARLEN_SINGLE;
            req.size = AXI_SIZE_WORD;
         end
      endcase
      return req;
   endfunction

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache to AXI read bridge: one outstanding request, single-beat
// or 8-beat line bursts, data returned to the cache one cycle after each beat.
module icache_axi_rd_bridge
   import icache_axi_rd_bridge_pkg::*;
#(
   parameter int                  AXI_ID_W = 4,
   parameter logic [AXI_ID_W-1:0] RD_ARID  = {AXI_ID_W{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   // cache side
   input  logic                rd_req,
   input  logic [2:0]          rd_type,
   input  logic [31:0]         rd_addr,
   output logic                rd_rdy,
   output logic                ret_valid,
   output logic                ret_last,
   output logic [31:0]         ret_data,
   output logic                bus_err,
   // AXI read address channel
   output logic [AXI_ID_W-1:0] arid,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,
   // AXI read data channel
   input  logic [AXI_ID_W-1:0] rid,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready
);

   state_e      state_q, state_d;
   ar_req_t     ar_q, ar_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ret_valid_q, ret_valid_d;
   logic        ret_last_q, ret_last_d;
   logic [31:0] ret_data_q, ret_data_d;
   logic        bus_err_q, bus_err_d;

   logic        rd_rdy_s;
   logic        arvalid_s;
   logic        rready_s;
   ar_req_t     req_s;
   logic        ar_hs_s;
   logic        r_hs_s;
   logic        beat_last_s;
   logic        rid_unused_s;

   // Only one ID is ever outstanding, so rid carries no information.
   assign rid_unused_s = ^rid;

   assign req_s       = build_ar_req(rd_type, rd_addr);
   assign ar_hs_s     = arvalid_s & arready;
   assign r_hs_s      = rready_s & rvalid;
   assign beat_last_s = ({5'b00000, cnt_q} == ar_q.len);

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: accept in IDLE, wait for AR handshake, drain to arlen.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               state_d = ST_AR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_AR: begin
            if (arready) begin
               state_d = ST_R;
            end else begin
               state_d = ST_AR;
            end
         end
         ST_R: begin
            if (rvalid && beat_last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_R;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: handshake enables decoded straight from the state register.
   always_comb begin
      rd_rdy_s  = 1'b0;
      arvalid_s = 1'b0;
      rready_s  = 1'b0;
      case (state_q)
         ST_IDLE: rd_rdy_s  = 1'b1;
         ST_AR:   arvalid_s = 1'b1;
         ST_R:    rready_s  = 1'b1;
         default: begin
            rd_rdy_s  = 1'b0;
            arvalid_s = 1'b0;
            rready_s  = 1'b0;
         end
      endcase
   end

   // Datapath next state: AR payload capture, beat counter, return beat.
   always_comb begin
      ar_d        = ar_q;
      cnt_d       = cnt_q;
      ret_data_d  = ret_data_q;
      ret_valid_d = r_hs_s;
      ret_last_d  = r_hs_s & beat_last_s;
      bus_err_d   = r_hs_s & ((rresp != AXI_RESP_OKAY) | (rlast != beat_last_s));

      if (rd_rdy_s && rd_req) begin
         ar_d = req_s;
      end else begin
         ar_d = ar_q;
      end

      // The counter saturates at the final beat so it never wraps in a request.
      if (ar_hs_s) begin
         cnt_d = 3'd0;
      end else if (r_hs_s && !beat_last_s) begin
         cnt_d = cnt_q + 3'd1;
      end else begin
         cnt_d = cnt_q;
      end

      if (r_hs_s) begin
         ret_data_d = rdata;
      end else begin
         ret_data_d = ret_data_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ar_q        <= '{addr: 32'h0000_0000, len: 8'd0, size: 3'd0, burst: 2'd0};
         cnt_q       <= 3'd0;
         ret_valid_q <= 1'b0;
         ret_last_q  <= 1'b0;
         ret_data_q  <= 32'h0000_0000;
         bus_err_q   <= 1'b0;
      end else begin
         ar_q        <= ar_d;
         cnt_q       <= cnt_d;
         ret_valid_q <= ret_valid_d;
         ret_last_q  <= ret_last_d;
         ret_data_q  <= ret_data_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign rd_rdy    = rd_rdy_s;
   assign arvalid   = arvalid_s;
   assign rready    = rready_s;
   assign arid      = RD_ARID;
   assign araddr    = ar_q.addr;
   assign arlen     = ar_q.len;
   assign arsize    = ar_q.size;
   assign arburst   = ar_q.burst;
   assign ret_valid = ret_valid_q;
   assign ret_last  = ret_last_q;
   assign ret_data  = ret_data_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed self-checking bench for icache_axi_rd_bridge.
module tb_icache_axi_rd_bridge;

   localparam int         ID_W = 4;
   localparam logic [3:0] ARID = 4'h5;
   localparam int         NONE = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   logic [2:0]  rd_type;
   logic [31:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [31:0] ret_data;
   logic        bus_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int checks   = 0;
   int failures = 0;

   icache_axi_rd_bridge #(.AXI_ID_W(ID_W), .RD_ARID(ARID)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .bus_err(bus_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a request in IDLE; returns at the first negedge in AR.
   task automatic issue_req(input string name, input logic [2:0] t, input logic [31:0] a);
      checks++;
      if (rd_rdy !== 1'b1 || ret_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin
         failures++;
         $display("FAIL %s idle: rd_rdy=%b ret_valid=%b arvalid=%b rready=%b, need 1 0 0 0",
                  name, rd_rdy, ret_valid, arvalid, rready);
      end
      rd_req  = 1'b1;
      rd_type = t;
      rd_addr = a;
      @(negedge clk);
      rd_req  = 1'b0;
      rd_type = 3'b000;
      rd_addr = 32'hDEAD_BEEF;
   endtask

   // Hold arready low for 'delay' cycles, checking the AR payload each cycle.
   task automatic ar_phase(input string name, input logic [31:0] ea, input logic [7:0] el,
                           input logic [2:0] es, input int delay);
      for (int k = 0; k <= delay; k++) begin
         checks++;
         if (arvalid !== 1'b1 || rd_rdy !== 1'b0 || rready !== 1'b0) begin
            failures++;
            $display("FAIL %s ar_ctl cyc%0d: arvalid=%b rd_rdy=%b rready=%b, need 1 0 0",
                     name, k, arvalid, rd_rdy, rready);
         end
         checks++;
         if (araddr !== ea || arlen !== el || arsize !== es || arburst !== 2'b01 || arid !== ARID) begin
            failures++;
            $display("FAIL %s ar_payload cyc%0d: addr=%h len=%0d size=%0d burst=%0d id=%0d, need %h %0d %0d 1 %0d",
                     name, k, araddr, arlen, arsize, arburst, arid, ea, el, es, ARID);
         end
         arready = (k == delay);
         @(negedge clk);
      end
      arready = 1'b0;
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b1) begin
         failures++;
         $display("FAIL %s ar_done: arvalid=%b rready=%b, need 0 1", name, arvalid, rready);
      end
   endtask

   // Drive an R burst cycle by cycle and check each returned beat one cycle later.
   task automatic run_burst(input string name, input int nbeats, input logic [31:0] dbase,
                            input int gap_after, input int gap_len,
                            input int err_beat, input int early_beat);
      int          i;
      int          gaps;
      logic        exp_v;
      logic [31:0] exp_d;
      logic        exp_l;
      logic        exp_e;
      logic        lst;
      i = 0; gaps = 0; exp_v = 1'b0; exp_d = 32'h0; exp_l = 1'b0; exp_e = 1'b0;
      while (i < nbeats || exp_v) begin
         checks++;
         if (ret_valid !== exp_v) begin
            failures++;
            $display("FAIL %s ret_valid after %0d beats: got %b need %b", name, i, ret_valid, exp_v);
         end
         checks++;
         if (exp_v && (ret_data !== exp_d || ret_last !== exp_l || bus_err !== exp_e)) begin
            failures++;
            $display("FAIL %s beat%0d: data=%h last=%b err=%b, need %h %b %b",
                     name, i, ret_data, ret_last, bus_err, exp_d, exp_l, exp_e);
         end else if (!exp_v && bus_err !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_err after %0d beats: bus_err=%b need 0", name, i, bus_err);
         end
         checks++;
         if (rd_rdy !== (i >= nbeats) || rready !== (i < nbeats)) begin
            failures++;
            $display("FAIL %s state after %0d beats: rd_rdy=%b rready=%b, need %b %b",
                     name, i, rd_rdy, rready, (i >= nbeats), (i < nbeats));
         end
         exp_v = 1'b0;
         if (i < nbeats && i == gap_after + 1 && gaps < gap_len) begin
            rvalid = 1'b0;
            rdata  = 32'hBAD0_0000;
            gaps++;
         end else if (i < nbeats) begin
            lst    = (i == nbeats - 1);
            rvalid = 1'b1;
            rdata  = dbase + i;
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = lst || (i == early_beat);
            rid    = 4'(i);
            exp_v  = 1'b1;
            exp_d  = dbase + i;
            exp_l  = lst;
            exp_e  = (i == err_beat) || (i == early_beat && !lst);
            i++;
         end else begin
            rvalid = 1'b0;
         end
         @(negedge clk);
         rvalid = 1'b0;
         rlast  = 1'b0;
         rresp  = 2'b00;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'h0;
      arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || ret_valid !== 1'b0 || ret_last !== 1'b0 ||
          bus_err !== 1'b0 || ret_data !== 32'h0 || araddr !== 32'h0 || arlen !== 8'd0 ||
          arsize !== 3'd0 || arburst !== 2'd0 || rd_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_values: arv=%b rr=%b rv=%b rl=%b err=%b rd=%h aa=%h al=%0d as=%0d ab=%0d rdy=%b",
                  arvalid, rready, ret_valid, ret_last, bus_err, ret_data, araddr, arlen, arsize, arburst, rd_rdy);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_rdy !== 1'b1 || arvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: rd_rdy=%b arvalid=%b, need 1 0", rd_rdy, arvalid);
      end
   endtask

   task automatic test_line_read;
      issue_req("line", 3'b100, 32'h1FC0_0014);
      ar_phase("line", 32'h1FC0_0000, 8'd7, 3'b010, 0);
      run_burst("line", 8, 32'hD000_0000, NONE, 0, NONE, NONE);
   endtask

   task automatic test_word_read;
      issue_req("word", 3'b010, 32'h0000_1004);
      ar_phase("word", 32'h0000_1004, 8'd0, 3'b010, 3);
      run_burst("word", 1, 32'h1234_5670, NONE, 0, NONE, NONE);
   endtask

   task automatic test_sizes;
      issue_req("byte", 3'b000, 32'h0000_2003);
      ar_phase("byte", 32'h0000_2003, 8'd0, 3'b000, 0);
      run_burst("byte", 1, 32'hB0B0_0000, NONE, 0, NONE, NONE);
      issue_req("half", 3'b001, 32'h0000_2002);
      ar_phase("half", 32'h0000_2002, 8'd0, 3'b001, 1);
      run_burst("half", 1, 32'hA1A1_0000, NONE, 0, NONE, NONE);
      issue_req("rsv011", 3'b011, 32'h0000_3006);
      ar_phase("rsv011", 32'h0000_3006, 8'd0, 3'b010, 0);
      run_burst("rsv011", 1, 32'hC3C3_0000, NONE, 0, NONE, NONE);
      issue_req("rsv111", 3'b111, 32'h0000_3FFF);
      ar_phase("rsv111", 32'h0000_3FFF, 8'd0, 3'b010, 0);
      run_burst("rsv111", 1, 32'hC7C7_0000, NONE, 0, NONE, NONE);
   endtask

   task automatic test_gapped;
      issue_req("gap", 3'b100, 32'h8000_005C);
      ar_phase("gap", 32'h8000_0040, 8'd7, 3'b010, 0);
      run_burst("gap", 8, 32'h6A60_0000, 2, 2, NONE, NONE);
   endtask

   task automatic test_error;
      issue_req("slverr", 3'b100, 32'h0000_0100);
      ar_phase("slverr", 32'h0000_0100, 8'd7, 3'b010, 1);
      run_burst("slverr", 8, 32'hE500_0000, NONE, 0, 4, NONE);
   endtask

   task automatic test_early_rlast;
      issue_req("early", 3'b100, 32'h0000_0220);
      ar_phase("early", 32'h0000_0220, 8'd7, 3'b010, 0);
      run_burst("early", 8, 32'hEA00_0000, NONE, 0, NONE, 5);
   endtask

   task automatic test_reset_mid_ar;
      issue_req("rst_ar", 3'b010, 32'h0000_4444);
      checks++;
      if (arvalid !== 1'b1) begin
         failures++;
         $display("FAIL rst_ar pre: arvalid=%b need 1", arvalid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (arvalid !== 1'b0 || rd_rdy !== 1'b1 || araddr !== 32'h0) begin
         failures++;
         $display("FAIL rst_ar drop: arvalid=%b rd_rdy=%b araddr=%h, need 0 1 0", arvalid, rd_rdy, araddr);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_rdy !== 1'b1 || arvalid !== 1'b0) begin
         failures++;
         $display("FAIL rst_ar release: rd_rdy=%b arvalid=%b, need 1 0", rd_rdy, arvalid);
      end
   endtask

   task automatic test_reset_mid_r;
      issue_req("rst_r", 3'b100, 32'h0000_0500);
      ar_phase("rst_r", 32'h0000_0500, 8'd7, 3'b010, 0);
      for (int b = 0; b < 2; b++) begin
         rvalid = 1'b1; rdata = 32'h5500_0000 + b; rresp = 2'b00; rlast = 1'b0;
         @(negedge clk);
      end
      rvalid = 1'b0;
      checks++;
      if (ret_valid !== 1'b1 || ret_data !== 32'h5500_0001 || rready !== 1'b1) begin
         failures++;
         $display("FAIL rst_r pre: ret_valid=%b data=%h rready=%b, need 1 55000001 1", ret_valid, ret_data, rready);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || ret_valid !== 1'b0 || ret_data !== 32'h0) begin
         failures++;
         $display("FAIL rst_r drop: arvalid=%b rready=%b ret_valid=%b data=%h, need 0 0 0 0",
                  arvalid, rready, ret_valid, ret_data);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_rdy !== 1'b1 || rready !== 1'b0 || ret_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_r release: rd_rdy=%b rready=%b ret_valid=%b, need 1 0 0", rd_rdy, rready, ret_valid);
      end
   endtask

   task automatic test_back_to_back;
      issue_req("b2b_a", 3'b010, 32'h0000_7000);
      ar_phase("b2b_a", 32'h0000_7000, 8'd0, 3'b010, 0);
      run_burst("b2b_a", 1, 32'h7A7A_0000, NONE, 0, NONE, NONE);
      issue_req("b2b_b", 3'b100, 32'h0000_703C);
      ar_phase("b2b_b", 32'h0000_7020, 8'd7, 3'b010, 2);
      run_burst("b2b_b", 8, 32'h7B7B_0000, 5, 1, 7, NONE);
   endtask

   initial begin
      test_reset();
      test_line_read();
      test_word_read();
      test_sizes();
      test_gapped();
      test_error();
      test_early_rlast();
      test_reset_mid_ar();
      test_reset_mid_r();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
